// File: rtl/regfile_dump_if.sv
// Request/read-port/stream bundle between regfile_dump and its register file and consumer.
// slave = the dump engine, master = whoever drives start/range, read data and out_ready.
interface regfile_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ctrl_start;
    logic [ADDR_W-1:0] ctrl_firstReg;
    logic [ADDR_W-1:0] ctrl_lastReg;
    logic [ADDR_W-1:0] ctrl_readReg;
    logic [DATA_W-1:0] data_readReg;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              out_sum;
    logic              busy;
    logic              done;

    modport slave (
        input  ctrl_start, ctrl_firstReg, ctrl_lastReg, data_readReg, out_ready,
        output ctrl_readReg, out_valid, out_data, out_addr, out_last, out_sum, busy, done
    );

    modport master (
        output ctrl_start, ctrl_firstReg, ctrl_lastReg, data_readReg, out_ready,
        input  ctrl_readReg, out_valid, out_data, out_addr, out_last, out_sum, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks registers first..last (wrapping mod 32) through one read port and streams them out; optional XOR checksum beat under REGFILE_DUMP_CHECKSUM_EN.
// Latency: start accepted in cycle N gives first out_valid in N+2; sustained 1 beat per 2 cycles; done pulses the cycle after the final handshake.
// Backpressure: a beat holds valid/data/addr/last/sum stable until out_ready; nothing advances without the handshake.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clock,
    input  logic           ctrl_reset,
    regfile_dump_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_FIN} state_e;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_last_q,  out_last_d;
    logic              busy_q,      busy_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic              out_sum_q,   out_sum_d;
`endif

    wire handshake = out_valid_q && bus.out_ready;
    wire at_last   = (ptr_q == last_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.ctrl_start) begin
                    ptr_d   = bus.ctrl_firstReg;
                    last_d  = bus.ctrl_lastReg;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_FETCH: begin
                out_data_d  = bus.data_readReg;
                out_addr_d  = ptr_q;
                out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                out_sum_d   = 1'b0;
`else
                out_last_d  = at_last;
`endif
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    if (out_sum_q) begin
                        out_valid_d = 1'b0;
                        state_d     = S_FIN;
                    end else if (at_last) begin
                        // Checksum beat follows straight on; valid stays high.
                        acc_d      = acc_q ^ out_data_q;
                        out_data_d = acc_q ^ out_data_q;
                        out_addr_d = '0;
                        out_last_d = 1'b1;
                        out_sum_d  = 1'b1;
                    end else begin
                        acc_d       = acc_q ^ out_data_q;
                        out_valid_d = 1'b0;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        state_d     = S_FETCH;
                    end
`else
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
`endif
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= '0;
            out_sum_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
`endif
        end
    end

    // Read port is only addressed while fetching; zero otherwise so idle dumps are quiet.
    assign bus.ctrl_readReg = (state_q == S_FETCH) ? ptr_q : '0;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_addr     = out_addr_q;
    assign bus.out_last     = out_last_q;
    assign bus.busy         = busy_q;
    assign bus.done         = (state_q == S_FIN);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign bus.out_sum      = out_sum_q;
`else
    assign bus.out_sum      = 1'b0;
`endif
endmodule
